multi_button_control: RTL and testbench



---
 rtl/multi_button_control.sv | 180 ++++++++++++++++++
 tb/tb_multi_button_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_button_control.sv
// rtl/multi_button_control.sv - debounced multi-channel button controller with press/long/release interrupts
module multi_button_control #(
  parameter int NUM_BTN     = 4,
  parameter int DEB_CNT     = 3,
  parameter int SHORT_TICKS = 8,
  parameter int LONG_TICKS  = 32
) (
  input  logic                 SlowClock,
  input  logic                 MainReset,
  input  logic                 Strobe16ms,
  input  logic                 Strobe125ms,
  input  logic [NUM_BTN-1:0]   ButtonIn,
  input  logic [NUM_BTN-1:0]   ChanEnable,
  input  logic [2*NUM_BTN-1:0] IntMask,
  input  logic [2*NUM_BTN-1:0] IntClear,
  output logic [NUM_BTN-1:0]   Debounced,
  output logic [NUM_BTN-1:0]   PressInt,
  output logic [NUM_BTN-1:0]   ReleaseInt,
  output logic [NUM_BTN-1:0]   LongStrobe,
  output logic [2*NUM_BTN-1:0] IntStatus,
  output logic                 IrqOut
);

  localparam int CW = $clog2(LONG_TICKS + 1);
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
  localparam logic [CW-1:0] SHORT_M1 = CW'(SHORT_TICKS - 1);
  localparam logic [CW-1:0] LONG_V   = CW'(LONG_TICKS);
  localparam logic [DW-1:0] DEB_M1   = DW'(DEB_CNT - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  typedef enum logic [2:0] {
    IDLE, DEB_PRESS, HELD, LONG, DEB_RELEASE
  } state_t;

  logic [NUM_BTN-1:0]   sync1_q, sync2_q;
  logic [2*NUM_BTN-1:0] status_q;
  logic                 irq_q;

  // two-flop synchroniser; resets to the released level so no false press
  always_ff @(posedge SlowClock or posedge MainReset) begin
    if (MainReset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= ButtonIn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          ret_long_q, ret_long_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          smp;

    assign smp = sync2_q[g];

    // channel state register
    always_ff @(posedge SlowClock or posedge MainReset) begin
      if (MainReset) begin
        state_q    <= IDLE;
        hold_q     <= '0;
        deb_q      <= '0;
        ret_long_q <= 1'b0;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        hold_q     <= hold_d;
        deb_q      <= deb_d;
        ret_long_q <= ret_long_d;
        press_q    <= press_d;
        rel_q      <= rel_d;
      end
    end

    // next state; both strobes are evaluated against start-of-cycle state
    always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      deb_d      = deb_q;
      ret_long_d = ret_long_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;

      // hold counter runs while the button is considered down, saturating
      if ((state_q == HELD || state_q == LONG || state_q == DEB_RELEASE) &&
          Strobe125ms && hold_q != LONG_V) begin
        hold_d = hold_q + CW'(1);
        if (hold_q == SHORT_M1) press_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          hold_d = '0;
          if (Strobe16ms && !smp) begin
            if (DEB_CNT == 1) begin
              state_d = HELD;
            end else begin
              state_d = DEB_PRESS;
              deb_d   = DEB_ONE;
            end
          end
        end
        DEB_PRESS: begin
          if (Strobe16ms) begin
            if (smp) begin
              state_d = IDLE;
            end else if (deb_q == DEB_M1) begin
              state_d = HELD;
              hold_d  = '0;
            end else begin
              deb_d = deb_q + DEB_ONE;
            end
          end
        end
        HELD, LONG: begin
          if (Strobe16ms && smp) begin
            if (DEB_CNT == 1) begin
              state_d = IDLE;
              rel_d   = 1'b1;
            end else begin
              state_d    = DEB_RELEASE;
              deb_d      = DEB_ONE;
              ret_long_d = (state_q == LONG) || (hold_d == LONG_V);
            end
          end else if (state_q == HELD && hold_d == LONG_V) begin
            state_d = LONG;
          end
        end
        DEB_RELEASE: begin
          if (Strobe16ms) begin
            if (!smp) begin
              state_d = ret_long_q ? LONG : HELD;
            end else if (deb_q == DEB_M1) begin
              state_d = IDLE;
              rel_d   = 1'b1;
            end else begin
              deb_d = deb_q + DEB_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // a disabled channel is held quiet in IDLE
      if (!ChanEnable[g]) begin
        state_d    = IDLE;
        hold_d     = '0;
        deb_d      = '0;
        ret_long_d = 1'b0;
        press_d    = 1'b0;
        rel_d      = 1'b0;
      end
    end

    assign Debounced[g]  = !(state_q == HELD || state_q == LONG || state_q == DEB_RELEASE);
    assign LongStrobe[g] = (state_q == LONG) || (state_q == DEB_RELEASE && ret_long_q);
    assign PressInt[g]   = press_q;
    assign ReleaseInt[g] = rel_q;
  end

  // sticky interrupt flags; a new event outranks a clear in the same cycle
  always_ff @(posedge SlowClock or posedge MainReset) begin
    if (MainReset) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~IntClear) | {ReleaseInt, PressInt};
      irq_q    <= |(status_q & IntMask);
    end
  end

  assign IntStatus = status_q;
  assign IrqOut    = irq_q;

endmodule

// File: tb/tb_multi_button_control.sv
// tb/tb_multi_button_control.sv - directed self-checking bench for multi_button_control
module tb_multi_button_control;

  logic       SlowClock = 1'b0;
  logic       MainReset;
  logic       Strobe16ms, Strobe125ms;
  logic [3:0] ButtonIn, ChanEnable;
  logic [7:0] IntMask, IntClear;
  logic [3:0] Debounced, PressInt, ReleaseInt, LongStrobe;
  logic [7:0] IntStatus;
  logic       IrqOut;

  int checks = 0;
  int failures = 0;
  int press_cnt [4] = '{0, 0, 0, 0};
  int rel_cnt   [4] = '{0, 0, 0, 0};

  multi_button_control #(
    .NUM_BTN(4), .DEB_CNT(3), .SHORT_TICKS(8), .LONG_TICKS(32)
  ) dut (
    .SlowClock(SlowClock), .MainReset(MainReset),
    .Strobe16ms(Strobe16ms), .Strobe125ms(Strobe125ms),
    .ButtonIn(ButtonIn), .ChanEnable(ChanEnable),
    .IntMask(IntMask), .IntClear(IntClear),
    .Debounced(Debounced), .PressInt(PressInt), .ReleaseInt(ReleaseInt),
    .LongStrobe(LongStrobe), .IntStatus(IntStatus), .IrqOut(IrqOut)
  );

  always #5 SlowClock = ~SlowClock;

  // pulse counters sampled mid-cycle
  always @(negedge SlowClock) begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] += int'(PressInt[i]);
      rel_cnt[i]   += int'(ReleaseInt[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge SlowClock);
      #1;
    end
  endtask

  task automatic s16(input int n);
    repeat (n) begin
      Strobe16ms = 1'b1;
      cyc(1);
      Strobe16ms = 1'b0;
      cyc(1);
    end
  endtask

  task automatic t125(input int n);
    repeat (n) begin
      Strobe125ms = 1'b1;
      cyc(1);
      Strobe125ms = 1'b0;
      cyc(1);
    end
  endtask

  int p_base, r_base;

  initial begin
    MainReset = 1'b1; Strobe16ms = 1'b0; Strobe125ms = 1'b0;
    ButtonIn = 4'hF; ChanEnable = 4'hF; IntMask = 8'h00; IntClear = 8'h00;
    cyc(3);
    check("rst_deb", Debounced, 4'hF);
    check("rst_press", PressInt, 4'h0);
    check("rst_rel", ReleaseInt, 4'h0);
    check("rst_long", LongStrobe, 4'h0);
    check("rst_stat", IntStatus, 8'h00);
    check("rst_irq", IrqOut, 1'b0);
    MainReset = 1'b0;
    cyc(2);

    // short glitch on ch0: two low samples only
    ButtonIn = 4'hE; cyc(3); s16(2);
    check("glitch_deb_low", Debounced, 4'hF);
    ButtonIn = 4'hF; cyc(3); s16(3);
    check("glitch_deb", Debounced, 4'hF);
    check("glitch_press", press_cnt[0], 0);
    check("glitch_stat", IntStatus, 8'h00);

    // ch1 long hold with a release bounce while long
    ButtonIn = 4'hD; cyc(3); s16(2);
    check("ch1_deb2", Debounced, 4'hF);
    s16(1);
    check("ch1_deb3", Debounced, 4'hD);
    t125(7);
    check("ch1_press7", press_cnt[1], 0);
    t125(1);
    check("ch1_press8", press_cnt[1], 1);
    check("ch1_stat_p", IntStatus, 8'h02);
    t125(23);
    check("ch1_long31", LongStrobe, 4'h0);
    t125(1);
    check("ch1_long32", LongStrobe, 4'h2);
    t125(8);
    ButtonIn = 4'hF; cyc(3); s16(1);
    check("ch1_bounce_long", LongStrobe, 4'h2);
    check("ch1_bounce_deb", Debounced, 4'hD);
    ButtonIn = 4'hD; cyc(3); s16(1);
    check("ch1_back_long", LongStrobe, 4'h2);
    ButtonIn = 4'hF; cyc(3); s16(2);
    check("ch1_rel2_long", LongStrobe, 4'h2);
    s16(1);
    check("ch1_rel_deb", Debounced, 4'hF);
    check("ch1_rel_long", LongStrobe, 4'h0);
    check("ch1_rel_cnt", rel_cnt[1], 1);
    check("ch1_press_once", press_cnt[1], 1);
    check("ch1_stat", IntStatus, 8'h22);

    // clear vs set collision on ch1 press bit
    IntClear = 8'h20; cyc(1); IntClear = 8'h00;
    check("clr_rel_bit", IntStatus, 8'h02);
    IntMask = 8'h02; cyc(2);
    check("irq_on", IrqOut, 1'b1);
    ButtonIn = 4'hD; cyc(3); s16(3); t125(7);
    Strobe125ms = 1'b1; cyc(1); Strobe125ms = 1'b0;
    check("coll_pulse", PressInt, 4'h2);
    IntClear = 8'h02; cyc(1); IntClear = 8'h00;
    check("coll_stat", IntStatus, 8'h02);
    cyc(1);
    check("coll_irq", IrqOut, 1'b1);
    ButtonIn = 4'hF; cyc(3); s16(3);
    IntClear = 8'hFF; cyc(1); IntClear = 8'h00;
    check("clr_all", IntStatus, 8'h00);
    cyc(1);
    check("irq_off", IrqOut, 1'b0);
    IntMask = 8'h00;

    // ch2 disabled mid-hold
    ButtonIn = 4'hB; cyc(3); s16(3); t125(20);
    check("ch2_deb", Debounced, 4'hB);
    r_base = rel_cnt[2];
    ChanEnable = 4'hB; cyc(1);
    check("ch2_dis_deb", Debounced, 4'hF);
    s16(3); t125(2);
    check("ch2_dis_hold_deb", Debounced, 4'hF);
    ButtonIn = 4'hF; cyc(3); s16(3);
    ChanEnable = 4'hF; cyc(2);
    check("ch2_no_rel", rel_cnt[2] - r_base, 0);
    check("ch2_stat", IntStatus, 8'h04);
    IntClear = 8'hFF; cyc(1); IntClear = 8'h00;

    // reset in the middle of a ch3 hold
    ButtonIn = 4'h7; cyc(3); s16(3); t125(10);
    check("ch3_stat_pre", IntStatus, 8'h08);
    MainReset = 1'b1; #2;
    check("ch3_rst_deb", Debounced, 4'hF);
    check("ch3_rst_stat", IntStatus, 8'h00);
    cyc(1);
    MainReset = 1'b0;
    r_base = rel_cnt[3]; p_base = press_cnt[3];
    cyc(3); s16(2);
    check("ch3_redeb2", Debounced, 4'hF);
    s16(1);
    check("ch3_redeb3", Debounced, 4'h7);
    t125(7);
    check("ch3_press7", press_cnt[3] - p_base, 0);
    t125(1);
    check("ch3_press8", press_cnt[3] - p_base, 1);
    check("ch3_no_rel", rel_cnt[3] - r_base, 0);
    ButtonIn = 4'hF; cyc(3); s16(3);
    IntClear = 8'hFF; cyc(1); IntClear = 8'h00;

    // all channels pressed together for 1.5 s
    ButtonIn = 4'h0; cyc(3); s16(3);
    check("all_deb", Debounced, 4'h0);
    t125(7);
    Strobe125ms = 1'b1; cyc(1); Strobe125ms = 1'b0;
    check("all_press", PressInt, 4'hF);
    cyc(1);
    check("all_stat", IntStatus, 8'h0F);
    t125(4);
    check("all_long", LongStrobe, 4'h0);
    ButtonIn = 4'hF; cyc(3); s16(3); cyc(1);
    check("all_rel_stat", IntStatus, 8'hFF);
    check("all_rel_deb", Debounced, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
